io_bridge_rr: RTL and testbench
===============================

# io_bridge_rr

Parametrised I/O bridge between NPORT CPU-side Wishbone-style initiator ports and one shared, registered I/O device bus. It filters each request against a programmable address window, picks between contending ports with a fair round-robin arbiter, and pipelines the access through registers. A watchdog completes stuck cycles with a bus error. It replaces fixed two-port, fixed-priority bridging in the SoC I/O path.

## Interface
- NPORT, 2: number of initiator ports (1..8)
- WID, 32: data width in bits; byte-lane width is WID/8
- AWID, 32: address width
- IO_BASE, 32'hFD000000: window base; a request is accepted when (adr & IO_MASK) == IO_BASE
- IO_MASK, 32'hFF000000: window mask
- TMO, 1023: cycles to wait for m_ack_i before a timeout error (≥2)

- clk_i  in  1  clock; all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- s_cyc_i, s_stb_i, s_we_i  in  [NPORT]  per-port cycle, strobe, write
- s_sel_i  in  [NPORT][WID/8]  byte selects
- s_adr_i  in  [NPORT][AWID]  address
- s_dat_i  in  [NPORT][WID]  write data
- s_ack_o, s_err_o  out  [NPORT]  registered acknowledge and error
- s_dat_o  out  [NPORT][WID]  read data; zero unless that port is acked
- m_cyc_o, m_stb_o, m_we_o  out  1  device-bus controls
- m_sel_o  out  WID/8, m_adr_o  out  AWID, m_dat_o  out  WID
- m_ack_i, m_err_i  in  1  device acknowledge and error
- m_dat_i  in  WID  device read data

## Operation
- Port p requests when s_cyc_i[p] & s_stb_i[p] & its address is in the window. Out-of-window requests are ignored: no ack, no error. Another target is expected to answer them.
- States are IDLE, WAIT_ACK, WAIT_NACK.
- IDLE: arbitration happens only while m_ack_i=0, so a stale device ack cannot be taken for a new request.
  - The winner is the first requester at or after rr_ptr, searching upward with wrap from NPORT-1 to 0.
  - The bridge latches the grant index g and drives m_* from port g with m_cyc_o=m_stb_o=1, then enters WAIT_ACK.
  - rr_ptr becomes g+1 mod NPORT.
- WAIT_ACK: tmo_cnt increments each cycle. Exits are checked in this priority order:
  1. m_ack_i: capture m_dat_i into s_dat_o[g], set s_ack_o[g], clear the bus, go to WAIT_NACK.
  2. m_err_i: set s_err_o[g] with s_dat_o[g]=0, clear the bus, go to WAIT_NACK.
  3. s_cyc_i[g]=0 (abort): clear the bus, go to IDLE, no ack.
  4. tmo_cnt==TMO: set s_err_o[g], clear the bus, go to WAIT_NACK.
- WAIT_NACK: s_ack_o[g]/s_err_o[g] are held until s_stb_i[g]=0 or s_cyc_i[g]=0. Then both are cleared, s_dat_o[g] is zeroed, and the state returns to IDLE.
- Clear bus means: m_cyc_o, m_stb_o, m_we_o = 0; m_sel_o, m_adr_o, m_dat_o = 0.
- Non-granted ports never see ack or error. Their requests wait while the bridge is busy.
- tmo_cnt is clog2(TMO+1) bits wide and saturates. It is cleared on entry to WAIT_ACK.

## Timing
- Reset: every output is 0. The state is IDLE, rr_ptr=0, tmo_cnt=0. Reset asserted mid-transaction ends that transaction silently on the next edge.
- Request-to-bus latency: request sampled at edge n; m_cyc_o is high after edge n.
- Device response: m_ack_i sampled at edge k; s_ack_o[g] and s_dat_o[g] are valid after edge k.
- Minimum transaction: 3 cycles from request to ack if the device acks in the same cycle as m_cyc_o.
- One idle cycle follows each WAIT_NACK exit before the next grant. Back-to-back requests from different ports therefore alternate fairly.
- If m_ack_i and m_err_i arrive together, ack wins.
- If an abort and m_ack_i arrive in the same cycle, the ack is taken. It is then dropped in WAIT_NACK because cyc is already low.
- A timeout fires exactly TMO cycles after WAIT_ACK entry.

## Structure
- io_bridge_pkg holds the state enum (IDLE, WAIT_ACK, WAIT_NACK) and the window-match function.
- rr_arbiter is a sub-module: NPORT request inputs, ptr input, one-hot grant and binary index outputs, purely combinational. Reuse it elsewhere.
- The datapath mux and the FSM live in io_bridge_rr.

## Test plan
- Single read: port0 reads 0xFD001000 and the device acks 2 cycles later with 0x12345678 -> s_ack_o[0]=1 with s_dat_o[0]=0x12345678. m_cyc_o falls the cycle after m_ack_i.
- Contention: ports 0 and 1 request continuously after reset -> grants in the order 0,1,0,1. No ack ever reaches the non-granted port.
- Window filter: port1 accesses 0xFE000000 -> m_cyc_o stays 0 and no ack is given. An access to 0xFDFFFFFC is bridged.
- Timeout with TMO=8: the device never acks -> s_err_o[g]=1 exactly 8 cycles after WAIT_ACK entry. It clears once cyc drops.
- Abort: port0 drops cyc in WAIT_ACK -> the bus clears the next cycle with no ack or error. A later device ack in IDLE is ignored.
- Reset mid-cycle: rst_i asserted during WAIT_ACK -> all outputs are 0 the next cycle and rr_ptr=0.

Source files
------------

// File: rtl/io_bridge_pkg.sv
// Shared types and helpers for the round-robin I/O bridge.
package io_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_NACK
  } state_t;

  // Callers zero-extend their address, base and mask to 64 bits.
  function automatic logic in_window(input logic [63:0] adr,
                                     input logic [63:0] base,
                                     input logic [63:0] mask);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr) + k) % N);
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/io_bridge_rr.sv
// Windowed, round-robin arbitrated bridge from NPORT initiators onto one
// registered device bus, with a watchdog that errors out stuck cycles.
module io_bridge_rr
  import io_bridge_pkg::*;
#(
  parameter int unsigned    NPORT   = 2,
  parameter int unsigned    WID     = 32,
  parameter int unsigned    AWID    = 32,
  parameter logic [AWID-1:0] IO_BASE = AWID'(32'hFD000000),
  parameter logic [AWID-1:0] IO_MASK = AWID'(32'hFF000000),
  parameter int unsigned    TMO     = 1023
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NPORT-1:0]               s_cyc_i,
  input  logic [NPORT-1:0]               s_stb_i,
  input  logic [NPORT-1:0]               s_we_i,
  input  logic [NPORT-1:0][WID/8-1:0]    s_sel_i,
  input  logic [NPORT-1:0][AWID-1:0]     s_adr_i,
  input  logic [NPORT-1:0][WID-1:0]      s_dat_i,
  output logic [NPORT-1:0]               s_ack_o,
  output logic [NPORT-1:0]               s_err_o,
  output logic [NPORT-1:0][WID-1:0]      s_dat_o,
  output logic                           m_cyc_o,
  output logic                           m_stb_o,
  output logic                           m_we_o,
  output logic [WID/8-1:0]               m_sel_o,
  output logic [AWID-1:0]                m_adr_o,
  output logic [WID-1:0]                 m_dat_o,
  input  logic                           m_ack_i,
  input  logic                           m_err_i,
  input  logic [WID-1:0]                 m_dat_i
);

  localparam int unsigned IW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned TW = $clog2(TMO + 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   g_q, rr_ptr, win_idx;
  logic [TW-1:0]   tmo_q, tmo_nxt;
  logic [NPORT-1:0] req, arb_gnt;
  logic            take, do_ack, do_err, do_clear, do_release;

  always_comb begin
    req = '0;
    for (int unsigned p = 0; p < NPORT; p++)
      req[p] = s_cyc_i[p] & s_stb_i[p] &
               in_window(64'(s_adr_i[p]), 64'(IO_BASE), 64'(IO_MASK));
  end

  rr_arbiter #(.N(NPORT), .IW(IW)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (win_idx)
  );

  // Timeout is judged on the incremented count so the error lands TMO cycles after entry.
  assign tmo_nxt = (tmo_q == TW'(TMO)) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    do_ack     = 1'b0;
    do_err     = 1'b0;
    do_clear   = 1'b0;
    do_release = 1'b0;
    case (state_q)
      IDLE: begin
        if (!m_ack_i && |arb_gnt) begin
          take    = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (m_ack_i) begin
          do_ack   = 1'b1;
          do_clear = 1'b1;
          state_d  = WAIT_NACK;
        end else if (m_err_i) begin
          do_err   = 1'b1;
          do_clear = 1'b1;
          state_d  = WAIT_NACK;
        end else if (!s_cyc_i[g_q]) begin
          do_clear = 1'b1;
          state_d  = IDLE;
        end else if (tmo_nxt == TW'(TMO)) begin
          do_err   = 1'b1;
          do_clear = 1'b1;
          state_d  = WAIT_NACK;
        end
      end
      WAIT_NACK: begin
        if (!s_stb_i[g_q] || !s_cyc_i[g_q]) begin
          do_release = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      g_q     <= '0;
      rr_ptr  <= '0;
      tmo_q   <= '0;
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_sel_o <= '0;
      m_adr_o <= '0;
      m_dat_o <= '0;
      s_ack_o <= '0;
      s_err_o <= '0;
      s_dat_o <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        g_q     <= win_idx;
        rr_ptr  <= (win_idx == IW'(NPORT - 1)) ? '0 : win_idx + 1'b1;
        tmo_q   <= '0;
        m_cyc_o <= 1'b1;
        m_stb_o <= 1'b1;
        m_we_o  <= s_we_i[win_idx];
        m_sel_o <= s_sel_i[win_idx];
        m_adr_o <= s_adr_i[win_idx];
        m_dat_o <= s_dat_i[win_idx];
      end else if (state_q == WAIT_ACK) begin
        tmo_q <= tmo_nxt;
      end
      if (do_clear) begin
        m_cyc_o <= 1'b0;
        m_stb_o <= 1'b0;
        m_we_o  <= 1'b0;
        m_sel_o <= '0;
        m_adr_o <= '0;
        m_dat_o <= '0;
      end
      if (do_ack) begin
        s_ack_o[g_q] <= 1'b1;
        s_dat_o[g_q] <= m_dat_i;
      end
      if (do_err) begin
        s_err_o[g_q] <= 1'b1;
        s_dat_o[g_q] <= '0;
      end
      if (do_release) begin
        s_ack_o[g_q] <= 1'b0;
        s_err_o[g_q] <= 1'b0;
        s_dat_o[g_q] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_io_bridge_rr.sv
// Directed bench for io_bridge_rr with a transaction-level reference model.
module tb_io_bridge_rr;

  localparam int NP  = 2;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]            s_cyc, s_stb, s_we;
  logic [NP-1:0][3:0]       s_sel;
  logic [NP-1:0][31:0]      s_adr, s_dat_w;
  logic [NP-1:0]            s_ack, s_err;
  logic [NP-1:0][31:0]      s_dat_r;
  logic                     m_cyc_o, m_stb_o, m_we_o;
  logic [3:0]               m_sel_o;
  logic [31:0]              m_adr_o, m_dat_o;
  logic                     m_ack_i, m_err_i;
  logic [31:0]              m_dat_i;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  io_bridge_rr #(
    .NPORT (NP),
    .WID   (32),
    .AWID  (32),
    .IO_BASE(32'hFD000000),
    .IO_MASK(32'hFF000000),
    .TMO   (TMO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .s_cyc_i (s_cyc),
    .s_stb_i (s_stb),
    .s_we_i  (s_we),
    .s_sel_i (s_sel),
    .s_adr_i (s_adr),
    .s_dat_i (s_dat_w),
    .s_ack_o (s_ack),
    .s_err_o (s_err),
    .s_dat_o (s_dat_r),
    .m_cyc_o (m_cyc_o),
    .m_stb_o (m_stb_o),
    .m_we_o  (m_we_o),
    .m_sel_o (m_sel_o),
    .m_adr_o (m_adr_o),
    .m_dat_o (m_dat_o),
    .m_ack_i (m_ack_i),
    .m_err_i (m_err_i),
    .m_dat_i (m_dat_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                  started = 1'b0;
  int                  phase, owner, pref, waited;
  logic                exp_cyc, exp_we;
  logic [3:0]          exp_sel;
  logic [31:0]         exp_adr, exp_mdat;
  logic [NP-1:0]       exp_ack, exp_err;
  logic [NP-1:0][31:0] exp_sdat;

  function automatic bit wants(input int p);
    return s_cyc[p] && s_stb[p] && ((s_adr[p] & 32'hFF000000) == 32'hFD000000);
  endfunction

  task automatic clear_bus();
    exp_cyc = 1'b0; exp_we = 1'b0; exp_sel = '0; exp_adr = '0; exp_mdat = '0;
  endtask

  always @(posedge clk) begin : model
    started = 1'b1;
    if (rst) begin
      phase = 0; owner = 0; pref = 0; waited = 0;
      clear_bus();
      exp_ack = '0; exp_err = '0; exp_sdat = '0;
    end else begin
      case (phase)
        0: if (!m_ack_i) begin
          bit found;
          found = 1'b0;
          for (int off = 0; off < NP; off++) begin
            int p;
            p = (pref + off) % NP;
            if (!found && wants(p)) begin
              found = 1'b1; owner = p; phase = 1; waited = 0;
              exp_cyc = 1'b1; exp_we = s_we[p]; exp_sel = s_sel[p];
              exp_adr = s_adr[p]; exp_mdat = s_dat_w[p];
              pref = (p + 1) % NP;
            end
          end
        end
        1: begin
          waited++;
          if (m_ack_i) begin
            exp_ack[owner] = 1'b1; exp_sdat[owner] = m_dat_i; clear_bus(); phase = 2;
          end else if (m_err_i) begin
            exp_err[owner] = 1'b1; exp_sdat[owner] = '0; clear_bus(); phase = 2;
          end else if (!s_cyc[owner]) begin
            clear_bus(); phase = 0;
          end else if (waited == TMO) begin
            exp_err[owner] = 1'b1; exp_sdat[owner] = '0; clear_bus(); phase = 2;
          end
        end
        default: if (!s_stb[owner] || !s_cyc[owner]) begin
          exp_ack[owner] = 1'b0; exp_err[owner] = 1'b0; exp_sdat[owner] = '0; phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      chk("m_cyc_o", 64'(m_cyc_o), 64'(exp_cyc));
      chk("m_stb_o", 64'(m_stb_o), 64'(exp_cyc));
      chk("m_we_o",  64'(m_we_o),  64'(exp_we));
      chk("m_sel_o", 64'(m_sel_o), 64'(exp_sel));
      chk("m_adr_o", 64'(m_adr_o), 64'(exp_adr));
      chk("m_dat_o", 64'(m_dat_o), 64'(exp_mdat));
      chk("s_ack_o", 64'(s_ack),   64'(exp_ack));
      chk("s_err_o", 64'(s_err),   64'(exp_err));
      chk("s_dat_o", 64'(s_dat_r), 64'(exp_sdat));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int p, input logic [31:0] a, input logic we, input logic [31:0] d);
    s_cyc[p] = 1'b1; s_stb[p] = 1'b1; s_adr[p] = a; s_we[p] = we; s_dat_w[p] = d; s_sel[p] = 4'hF;
  endtask

  task automatic drop(input int p);
    s_cyc[p] = 1'b0; s_stb[p] = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int order[$];
    rst = 1'b1;
    s_cyc = '0; s_stb = '0; s_we = '0; s_sel = '0; s_adr = '0; s_dat_w = '0;
    m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = '0;
    repeat (2) tick();
    chk("rst_cyc", 64'(m_cyc_o), 64'(0));
    chk("rst_ack", 64'(s_ack), 64'(0));
    chk("rst_dat", 64'(s_dat_r), 64'(0));
    rst = 1'b0;
    tick();

    // single read, device acks two cycles after m_cyc rises
    req(0, 32'hFD001000, 1'b0, '0);
    tick();
    chk("rd_cyc", 64'(m_cyc_o), 64'(1));
    chk("rd_adr", 64'(m_adr_o), 64'(32'hFD001000));
    tick();
    m_ack_i = 1'b1; m_dat_i = 32'h12345678;
    tick();
    m_ack_i = 1'b0; m_dat_i = '0;
    chk("rd_ack", 64'(s_ack[0]), 64'(1));
    chk("rd_data", 64'(s_dat_r[0]), 64'(32'h12345678));
    chk("rd_cyc_fall", 64'(m_cyc_o), 64'(0));
    drop(0);
    tick();
    chk("rd_release", 64'(s_ack), 64'(0));
    chk("rd_dat_zero", 64'(s_dat_r[0]), 64'(0));

    // contention straight after reset: grants must alternate 0,1,0,1
    rst = 1'b1; tick(); rst = 1'b0;
    req(0, 32'hFD000100, 1'b0, '0);
    req(1, 32'hFD000200, 1'b0, '0);
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      tick();
      m_ack_i = 1'b0;
      if (m_cyc_o) begin
        order.push_back((m_adr_o == 32'hFD000200) ? 1 : 0);
        m_ack_i = 1'b1; m_dat_i = m_adr_o;
      end
      for (int p = 0; p < NP; p++) s_stb[p] = !s_ack[p];
    end
    chk("rr_count", 64'(order.size()), 64'(4));
    for (int i = 0; i < order.size(); i++) chk("rr_order", 64'(order[i]), 64'(i % 2));
    drop(0); drop(1);
    tick(); m_ack_i = 1'b0; m_dat_i = '0;
    tick(); tick();

    // window filter
    req(1, 32'hFE000000, 1'b0, '0);
    repeat (4) begin
      tick();
      chk("win_cyc", 64'(m_cyc_o), 64'(0));
      chk("win_ack", 64'(s_ack), 64'(0));
    end
    req(1, 32'hFDFFFFFC, 1'b1, 32'hA5A50001);
    tick();
    chk("win_edge_cyc", 64'(m_cyc_o), 64'(1));
    chk("win_edge_adr", 64'(m_adr_o), 64'(32'hFDFFFFFC));
    chk("win_edge_we", 64'(m_we_o), 64'(1));
    chk("win_edge_dat", 64'(m_dat_o), 64'(32'hA5A50001));
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    chk("win_edge_ack", 64'(s_ack), 64'(2'b10));
    drop(1);
    tick(); tick();

    // watchdog timeout
    req(0, 32'hFD000000, 1'b0, '0);
    tick();
    chk("tmo_entry", 64'(m_cyc_o), 64'(1));
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("tmo_early", 64'(s_err[0]), 64'(0));
    end
    tick();
    chk("tmo_err", 64'(s_err[0]), 64'(1));
    chk("tmo_bus", 64'(m_cyc_o), 64'(0));
    tick();
    chk("tmo_hold", 64'(s_err[0]), 64'(1));
    drop(0);
    tick();
    chk("tmo_clear", 64'(s_err[0]), 64'(0));
    tick();

    // device error, with read data forced to zero
    req(1, 32'hFD000040, 1'b0, '0);
    tick();
    m_err_i = 1'b1; m_dat_i = 32'hCAFEF00D;
    tick();
    m_err_i = 1'b0; m_dat_i = '0;
    chk("derr_err", 64'(s_err), 64'(2'b10));
    chk("derr_dat", 64'(s_dat_r[1]), 64'(0));
    drop(1);
    tick(); tick();

    // abort, then a stray device ack in IDLE
    req(0, 32'hFD000010, 1'b0, '0);
    tick();
    chk("abt_cyc", 64'(m_cyc_o), 64'(1));
    drop(0);
    tick();
    chk("abt_bus", 64'(m_cyc_o), 64'(0));
    chk("abt_noresp", 64'({s_ack, s_err}), 64'(0));
    m_ack_i = 1'b1; m_dat_i = 32'hDEADBEEF;
    tick();
    m_ack_i = 1'b0; m_dat_i = '0;
    chk("abt_stray", 64'(s_ack), 64'(0));
    tick();

    // reset in WAIT_ACK; afterwards port 0 must win again
    req(0, 32'hFD000020, 1'b0, '0);
    tick();
    chk("mrst_cyc", 64'(m_cyc_o), 64'(1));
    rst = 1'b1;
    tick();
    chk("mrst_cyc0", 64'(m_cyc_o), 64'(0));
    chk("mrst_adr0", 64'(m_adr_o), 64'(0));
    rst = 1'b0;
    req(1, 32'hFD000030, 1'b0, '0);
    tick();
    chk("mrst_ptr", 64'(m_adr_o), 64'(32'hFD000020));
    m_ack_i = 1'b1;
    tick();
    m_ack_i = 1'b0;
    drop(0); drop(1);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
